pbit_gibbs_sched: RTL

PBIT_GIBBS_SCHED -- requirements
Module: pbit_gibbs_sched

---
 rtl/pbit_gibbs_sched_pkg.sv | 17 +
 rtl/pbit_gibbs_sched_if.sv | 13 +
 rtl/pbit_gibbs_sched_beta_sat_add.sv | 31 +++
 rtl/pbit_gibbs_sched.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pbit_gibbs_sched_pkg.sv
// Shared definitions for the p-bit Gibbs scheduler and the p-bit array top:
// FSM state encoding and the default fixed-point beta width.
package pbit_gibbs_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    SETTLE,
    EMIT,
    FINISH
  } state_e;

  localparam int unsigned INT_SIZE_DEF   = 8;
  localparam int unsigned FLOAT_SIZE_DEF = 24;
  localparam int unsigned FIX_W          = INT_SIZE_DEF + FLOAT_SIZE_DEF;

endpackage

// File: rtl/pbit_gibbs_sched_if.sv
// Sample output handshake: the scheduler drives a sweep snapshot, the consumer drives ready.
interface pbit_gibbs_sched_if #(
  parameter int unsigned N_PBITS = 3
);

  logic               SAMPLE_VALID;
  logic               SAMPLE_READY;
  logic [N_PBITS-1:0] SAMPLE_DATA;

  modport master (output SAMPLE_VALID, output SAMPLE_DATA, input  SAMPLE_READY);
  modport slave  (input  SAMPLE_VALID, input  SAMPLE_DATA, output SAMPLE_READY);

endinterface

// File: rtl/pbit_gibbs_sched_beta_sat_add.sv
// Combinational signed beta + step, clamped to max; the sum is formed one bit
// wider so an overflowing add clamps instead of wrapping.
module beta_sat_add
  import pbit_gibbs_sched_pkg::*;
#(
  parameter int unsigned W = FIX_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] max_val,
  output logic signed [W-1:0] sum
);

  localparam logic signed [W:0] MIN_EXT = {2'b11, {(W-1){1'b0}}};

  logic signed [W:0] full;
  logic signed [W:0] max_ext;

  always_comb begin
    full    = {a[W-1], a} + {b[W-1], b};
    max_ext = {max_val[W-1], max_val};
    if (full > max_ext) begin
      sum = max_val;
    end else if (full < MIN_EXT) begin
      sum = MIN_EXT[W-1:0];
    end else begin
      sum = full[W-1:0];
    end
  end

endmodule

// File: rtl/pbit_gibbs_sched.sv
// Gibbs-sampling sequencer: updates p-bits one at a time, settles, emits a
// per-sweep snapshot and anneals beta towards BETA_MAX after each sample.
module pbit_gibbs_sched
  import pbit_gibbs_sched_pkg::*;
#(
  parameter int unsigned N_PBITS    = 3,
  parameter int unsigned INT_SIZE   = INT_SIZE_DEF,
  parameter int unsigned FLOAT_SIZE = FLOAT_SIZE_DEF,
  parameter int unsigned SWEEP_W    = 16,
  parameter int unsigned SETTLE_W   = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  START,
  input  logic                                  ABORT,
  input  logic [SWEEP_W-1:0]                    NUM_SWEEPS,
  input  logic [SETTLE_W-1:0]                   SETTLE_CYC,
  input  logic signed [INT_SIZE+FLOAT_SIZE-1:0] BETA_INIT,
  input  logic signed [INT_SIZE+FLOAT_SIZE-1:0] BETA_STEP,
  input  logic signed [INT_SIZE+FLOAT_SIZE-1:0] BETA_MAX,
  input  logic [N_PBITS-1:0]                    PBIT_STATE,
  output logic [N_PBITS-1:0]                    UPD_EN,
  output logic signed [INT_SIZE+FLOAT_SIZE-1:0] BETA,
  output logic                                  BUSY,
  output logic                                  DONE,
  pbit_gibbs_sched_if.master                    smp
);

  localparam int unsigned FW    = INT_SIZE + FLOAT_SIZE;
  localparam int unsigned IDX_W = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PBITS - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [SETTLE_W-1:0]   settle_cfg_q, settle_cfg_d;
  logic [SWEEP_W-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic signed [FW-1:0]  beta_q, beta_d;
  logic signed [FW-1:0]  beta_step_q, beta_step_d;
  logic signed [FW-1:0]  beta_max_q, beta_max_d;
  logic signed [FW-1:0]  beta_sum;
  logic                  valid_q, valid_d;
  logic [N_PBITS-1:0]    data_q, data_d;
  logic                  hs;

  beta_sat_add #(.W(FW)) u_beta_sat_add (
    .a       (beta_q),
    .b       (beta_step_q),
    .max_val (beta_max_q),
    .sum     (beta_sum)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    settle_cfg_d = settle_cfg_q;
    sweep_cnt_d  = sweep_cnt_q;
    beta_d       = beta_q;
    beta_step_d  = beta_step_q;
    beta_max_d   = beta_max_q;
    valid_d      = valid_q;
    data_d       = data_q;
    hs           = valid_q && smp.SAMPLE_READY;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          sweep_cnt_d  = NUM_SWEEPS;
          settle_cfg_d = SETTLE_CYC;
          beta_d       = BETA_INIT;
          beta_step_d  = BETA_STEP;
          beta_max_d   = BETA_MAX;
          idx_d        = '0;
          state_d      = (NUM_SWEEPS == '0) ? FINISH : UPDATE;
        end
      end
      UPDATE: begin
        settle_cnt_d = settle_cfg_q;
        state_d      = SETTLE;
      end
      SETTLE: begin
        // A zero settle count still spends one cycle here, same as a count of 1.
        if (settle_cnt_q <= SETTLE_W'(1)) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = PBIT_STATE;
            state_d = EMIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = UPDATE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      EMIT: begin
        if (hs) begin
          valid_d     = 1'b0;
          sweep_cnt_d = sweep_cnt_q - SWEEP_W'(1);
          beta_d      = beta_sum;
          state_d     = (sweep_cnt_q == SWEEP_W'(1)) ? FINISH : UPDATE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort keeps a same-cycle sample handshake (counter already stepped above)
    // but drops its beta update.
    if (ABORT && state_q != IDLE && state_q != FINISH) begin
      state_d = FINISH;
      valid_d = 1'b0;
      data_d  = data_q;
      beta_d  = beta_q;
      idx_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      settle_cfg_q <= '0;
      sweep_cnt_q  <= '0;
      beta_q       <= '0;
      beta_step_q  <= '0;
      beta_max_q   <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      settle_cfg_q <= settle_cfg_d;
      sweep_cnt_q  <= sweep_cnt_d;
      beta_q       <= beta_d;
      beta_step_q  <= beta_step_d;
      beta_max_q   <= beta_max_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    UPD_EN = '0;
    if (state_q == UPDATE) begin
      UPD_EN[idx_q] = 1'b1;
    end
  end

  assign BETA             = beta_q;
  assign BUSY             = (state_q != IDLE);
  assign DONE             = (state_q == FINISH);
  assign smp.SAMPLE_VALID = valid_q;
  assign smp.SAMPLE_DATA  = data_q;

endmodule
